mem_arbiter_rr: RTL

- Parametrised N-port memory-bus arbiter; next generation of the core's two-port fetch/MMU arbiter.
- Sits between NUM_PORTS requesters (ifetch, load/store unit, future DMA/debug) and the single external memory bus.
- Supports round-robin or fixed-priority selection, one outstanding bus transaction, per-port flush cancellation and a global stall gate.
- Uses separate read/write data buses; the top level handles any inout conversion.

---
 rtl/mem_arbiter_rr_if.sv | 48 ++++
 rtl/mem_arbiter_rr.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr_if.sv
// ============================================================================
// Module      : mem_arbiter_rr_if
// Description : Requester/memory bus bundle for mem_arbiter_rr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface mem_arbiter_rr_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            flush;
  logic                            stall;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]           rsp_rdata;
  logic                            mem_req_valid;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic                            mem_we;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            data_valid;
  logic                            timeout_err;

  // Arbiter side
  modport slave (
    input  req_valid, req_addr, req_we, req_wdata, flush, stall,
    input  mem_rdata, data_valid,
    output grant, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_addr, mem_we, mem_wdata, timeout_err
  );

  // Requester / memory model side
  modport master (
    output req_valid, req_addr, req_we, req_wdata, flush, stall,
    output mem_rdata, data_valid,
    input  grant, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_addr, mem_we, mem_wdata, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// ============================================================================
// Module      : mem_arbiter_rr
// Description : N-port memory-bus arbiter, round-robin or fixed priority, one
//               outstanding transaction. Define ARB_TIMEOUT_EN for watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mem_arbiter_rr #(
  parameter int NUM_PORTS     = 2,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_arbiter_rr_if.slave   bus
);

  localparam int c_IDX_W = $clog2(NUM_PORTS);
  localparam logic [c_IDX_W:0] c_NP = (c_IDX_W+1)'(NUM_PORTS);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
    $error("mem_arbiter_rr: NUM_PORTS must be 2..8");
  end
  if (PRIORITY_MODE < 0 || PRIORITY_MODE > 1) begin : g_bad_priority_mode
    $error("mem_arbiter_rr: PRIORITY_MODE must be 0 or 1");
  end
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("mem_arbiter_rr: MAX_WAIT must be at least 1");
  end

  state_t                  r_state;
  logic [c_IDX_W-1:0]      r_ptr;
  logic [c_IDX_W-1:0]      r_owner;
  logic                    r_cancel;
  logic [NUM_PORTS-1:0]    r_grant;
  logic [NUM_PORTS-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_mem_req_valid;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic                    r_mem_we;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;

  logic [NUM_PORTS-1:0]    w_cand;
  logic                    w_found;
  logic [c_IDX_W-1:0]      w_win;
  logic [c_IDX_W:0]        w_sum;
  logic                    w_cancel_now;
  logic                    w_expire;

  logic [ADDR_WIDTH-1:0]   w_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]   w_wdata [NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign w_addr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(MAX_WAIT + 1);
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_timeout_err;

  // Fires in the MAX_WAIT-th BUSY cycle, counting the first BUSY cycle as 1
  assign w_expire        = (r_cnt == c_CNT_W'(MAX_WAIT - 1));
  assign bus.timeout_err = r_timeout_err;
`else
  assign w_expire        = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Flushed ports are excluded from the candidate set for this cycle
  always_comb begin
    w_cand  = bus.req_valid & ~bus.flush;
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    if (PRIORITY_MODE == 1) begin
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
        if (w_cand[c_IDX_W'(k)]) begin
          w_found = 1'b1;
          w_win   = c_IDX_W'(k);
        end
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        w_sum = {1'b0, r_ptr} + (c_IDX_W+1)'(k);
        if (w_sum >= c_NP) begin
          w_sum = w_sum - c_NP;
        end
        if (!w_found && w_cand[w_sum[c_IDX_W-1:0]]) begin
          w_found = 1'b1;
          w_win   = w_sum[c_IDX_W-1:0];
        end
      end
    end
  end

  // A flush landing in the completing cycle still suppresses the response
  assign w_cancel_now = r_cancel | bus.flush[r_owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_ptr           <= '0;
      r_owner         <= '0;
      r_cancel        <= 1'b0;
      r_grant         <= '0;
      r_rsp_valid     <= '0;
      r_rsp_rdata     <= '0;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_we        <= 1'b0;
      r_mem_wdata     <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt           <= '0;
      r_timeout_err   <= 1'b0;
`endif
    end else begin
      r_grant     <= '0;
      r_rsp_valid <= '0;
`ifdef ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (!bus.stall && w_found) begin
            r_grant[w_win]  <= 1'b1;
            r_mem_req_valid <= 1'b1;
            r_mem_addr      <= w_addr[w_win];
            r_mem_we        <= bus.req_we[w_win];
            r_mem_wdata     <= w_wdata[w_win];
            r_owner         <= w_win;
            r_ptr           <= (w_win == c_IDX_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
            r_cancel        <= 1'b0;
            r_state         <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt           <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (bus.data_valid) begin
            r_mem_req_valid <= 1'b0;
            r_rsp_rdata     <= bus.mem_rdata;
            if (!w_cancel_now) begin
              r_rsp_valid[r_owner] <= 1'b1;
            end
            r_cancel <= 1'b0;
            r_state  <= S_IDLE;
          end else if (w_expire) begin
            r_mem_req_valid <= 1'b0;
            r_rsp_rdata     <= '0;
            if (!w_cancel_now) begin
              r_rsp_valid[r_owner] <= 1'b1;
            end
            r_cancel <= 1'b0;
            r_state  <= S_IDLE;
`ifdef ARB_TIMEOUT_EN
            r_timeout_err <= 1'b1;
`endif
          end else begin
            if (bus.flush[r_owner]) begin
              r_cancel <= 1'b1;
            end
`ifdef ARB_TIMEOUT_EN
            r_cnt <= r_cnt + 1'b1;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant         = r_grant;
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_rdata     = r_rsp_rdata;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_we        = r_mem_we;
  assign bus.mem_wdata     = r_mem_wdata;

endmodule

`default_nettype wire
